rename_register_file: RTL and testbench

- Parametrised successor to the single-issue architectural register file with per-register ROB dependency tags.
- Adds configurable data width, register count, ROB tag width and number of read ports, plus an explicit busy bit per register so ROB tag 0 is a usable tag.
- Adds hardwired x0, same-cycle commit-to-read bypass, a global flush for mispredict recovery, and a stall mode that holds state without clearing it.
- Sits between the decoder/issue stage (reads), the ROB (launch/commit) and the reservation stations (commit broadcast).

---
 rtl/rename_register_file.sv | 134 +++++++++++++
 tb/tb_rename_register_file.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/rename_register_file.sv
// Rename register file.
// It holds architectural values plus a busy bit and a ROB tag for each register.
//
// Ports
//   clk_in, rst_in (sync, active-low), rdy_in (low = stall), flush_in.
//   launch_*: ROB allocates a producer for a destination register.
//   commit_*: ROB commits a result; it is broadcast on msg_* one cycle later.
//   ask_reg / dep_*: NUM_READ combinational read ports.
//   Each read port has a commit bypass.
module rename_register_file #(
    parameter int XLEN     = 32,
    parameter int NUM_REGS = 32,
    parameter int REG_W    = 5,
    parameter int ROB_ID_W = 5,
    parameter int NUM_READ = 2
) (
    input  logic                         clk_in,
    input  logic                         rst_in,
    input  logic                         rdy_in,
    input  logic                         flush_in,
    input  logic                         launch_valid,
    input  logic [ROB_ID_W-1:0]          launch_rob_id,
    input  logic [REG_W-1:0]             launch_reg,
    input  logic                         commit_valid,
    input  logic [ROB_ID_W-1:0]          commit_rob_id,
    input  logic [REG_W-1:0]             commit_reg,
    input  logic [XLEN-1:0]              commit_value,
    input  logic [NUM_READ*REG_W-1:0]    ask_reg,
    output logic [NUM_READ-1:0]          dep_busy,
    output logic [NUM_READ*ROB_ID_W-1:0] dep_tag,
    output logic [NUM_READ*XLEN-1:0]     dep_value,
    output logic                         msg_valid,
    output logic [ROB_ID_W-1:0]          msg_rob_id,
    output logic [XLEN-1:0]              msg_value
);

    logic [XLEN-1:0]     regs     [NUM_REGS];
    logic [ROB_ID_W-1:0] tag      [NUM_REGS];
    logic [NUM_REGS-1:0] busy;

    logic [XLEN-1:0]     regs_nxt [NUM_REGS];
    logic [ROB_ID_W-1:0] tag_nxt  [NUM_REGS];
    logic [NUM_REGS-1:0] busy_nxt;

    logic launch_ok;
    logic clr_ok;
    logic same_reg;

    // Next-state arrays. Priority is flush, then launch, then commit.
    always_comb begin
        regs_nxt  = regs;
        tag_nxt   = tag;
        busy_nxt  = busy;
        same_reg  = launch_valid && (launch_reg == commit_reg);
        launch_ok = launch_valid && !flush_in && (launch_reg != '0);
        // Only the youngest producer may clear busy.
        // A same-cycle relaunch keeps the register busy.
        clr_ok    = commit_valid && !flush_in && !same_reg
                    && busy[commit_reg]
                    && (tag[commit_reg] == commit_rob_id);

        if (commit_valid && (commit_reg != '0))
            regs_nxt[commit_reg] = commit_value;

        unique case (1'b1)
            flush_in: busy_nxt = '0;
            default: begin
                if (clr_ok)
                    busy_nxt[commit_reg] = 1'b0;
                if (launch_ok) begin
                    busy_nxt[launch_reg] = 1'b1;
                    tag_nxt[launch_reg]  = launch_rob_id;
                end
            end
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
                tag[i]  <= '0;
            end
            busy       <= '0;
            msg_valid  <= 1'b0;
            msg_rob_id <= '0;
            msg_value  <= '0;
        end else if (!rdy_in) begin
            // Hold everything; drop valid so a broadcast is never repeated.
            msg_valid <= 1'b0;
        end else begin
            regs      <= regs_nxt;
            tag       <= tag_nxt;
            busy      <= busy_nxt;
            msg_valid <= commit_valid;
            if (commit_valid) begin
                msg_rob_id <= commit_rob_id;
                msg_value  <= commit_value;
            end
        end
    end

    // The bypass is gated by rdy/rst so a read agrees with what the edge commits.
    logic byp_en;
    assign byp_en = commit_valid && rdy_in && rst_in;

    for (genvar k = 0; k < NUM_READ; k++) begin : g_rd
        logic [REG_W-1:0] ask;
        logic             hit;

        assign ask = ask_reg[k*REG_W +: REG_W];
        assign hit = byp_en && (commit_reg == ask) && busy[ask]
                     && (tag[ask] == commit_rob_id);

        always_comb begin
            dep_busy[k]                  = busy[ask];
            dep_tag[k*ROB_ID_W +: ROB_ID_W] = tag[ask];
            dep_value[k*XLEN +: XLEN]    = regs[ask];
            unique case (1'b1)
                (ask == '0): begin
                    dep_busy[k]                     = 1'b0;
                    dep_tag[k*ROB_ID_W +: ROB_ID_W] = '0;
                    dep_value[k*XLEN +: XLEN]       = '0;
                end
                hit: begin
                    dep_busy[k]               = 1'b0;
                    dep_value[k*XLEN +: XLEN] = commit_value;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_rename_register_file.sv
// Self-checking bench for rename_register_file.
// Directed steps; a queue of expected broadcasts is checked after each edge.
module tb_rename_register_file;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        flush_in;
    logic        launch_valid;
    logic [4:0]  launch_rob_id;
    logic [4:0]  launch_reg;
    logic        commit_valid;
    logic [4:0]  commit_rob_id;
    logic [4:0]  commit_reg;
    logic [31:0] commit_value;
    logic [9:0]  ask_reg;
    logic [1:0]  dep_busy;
    logic [9:0]  dep_tag;
    logic [63:0] dep_value;
    logic        msg_valid;
    logic [4:0]  msg_rob_id;
    logic [31:0] msg_value;

    rename_register_file dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .flush_in(flush_in),
        .launch_valid(launch_valid), .launch_rob_id(launch_rob_id),
        .launch_reg(launch_reg),
        .commit_valid(commit_valid), .commit_rob_id(commit_rob_id),
        .commit_reg(commit_reg), .commit_value(commit_value),
        .ask_reg(ask_reg),
        .dep_busy(dep_busy), .dep_tag(dep_tag), .dep_value(dep_value),
        .msg_valid(msg_valid), .msg_rob_id(msg_rob_id),
        .msg_value(msg_value)
    );

    always #5 clk_in = ~clk_in;

    typedef struct packed {
        logic [4:0]  id;
        logic [31:0] val;
    } msg_t;

    msg_t msg_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic chk(input string name, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    task automatic launch(input logic [4:0] r, input logic [4:0] id);
        launch_valid  = 1'b1;
        launch_reg    = r;
        launch_rob_id = id;
    endtask

    // Queue a broadcast only when this edge will really accept the commit.
    task automatic commit(input logic [4:0] r, input logic [4:0] id,
                          input logic [31:0] v);
        commit_valid  = 1'b1;
        commit_reg    = r;
        commit_rob_id = id;
        commit_value  = v;
        if (rdy_in && rst_in) msg_q.push_back('{id: id, val: v});
    endtask

    task automatic ask(input logic [4:0] p1, input logic [4:0] p0);
        ask_reg = {p1, p0};
        #1;
    endtask

    // One clock, then check the broadcast and return inputs to idle.
    task automatic tick();
        msg_t m;
        @(posedge clk_in);
        #1;
        if (msg_q.size() > 0) begin
            m = msg_q.pop_front();
            chk("msg_valid", {63'd0, msg_valid}, 64'd1);
            chk("msg_rob_id", {59'd0, msg_rob_id}, {59'd0, m.id});
            chk("msg_value", {32'd0, msg_value}, {32'd0, m.val});
        end else begin
            chk("msg_idle", {63'd0, msg_valid}, 64'd0);
        end
        launch_valid = 1'b0;
        commit_valid = 1'b0;
        flush_in     = 1'b0;
    endtask

    task automatic rd0(input string name, input logic b,
                       input logic [4:0] t, input logic [31:0] v);
        chk({name, "_busy"}, {63'd0, dep_busy[0]}, {63'd0, b});
        if (b) chk({name, "_tag"}, {59'd0, dep_tag[4:0]}, {59'd0, t});
        chk({name, "_val"}, {32'd0, dep_value[31:0]}, {32'd0, v});
    endtask

    initial begin
        rst_in = 1'b0; rdy_in = 1'b1; flush_in = 1'b0;
        launch_valid = 1'b0; launch_rob_id = '0; launch_reg = '0;
        commit_valid = 1'b0; commit_rob_id = '0; commit_reg = '0;
        commit_value = '0;
        ask_reg = {5'd5, 5'd0};
        @(posedge clk_in); @(posedge clk_in); #1;

        chk("rst_busy", {62'd0, dep_busy}, 64'd0);
        chk("rst_value", dep_value, 64'd0);
        chk("rst_msg", {63'd0, msg_valid}, 64'd0);
        rst_in = 1'b1;

        launch(5'd3, 5'd7);
        tick();
        ask(5'd0, 5'd3);
        rd0("l3", 1'b1, 5'd7, 32'd0);
        commit(5'd3, 5'd7, 32'hDEADBEEF);
        #1;
        rd0("byp3", 1'b0, 5'd0, 32'hDEADBEEF);
        tick();
        ask(5'd0, 5'd3);
        rd0("st3", 1'b0, 5'd0, 32'hDEADBEEF);

        launch(5'd4, 5'd2);
        tick();
        launch(5'd4, 5'd9);
        tick();
        commit(5'd4, 5'd2, 32'd5);
        ask(5'd0, 5'd4);
        rd0("stale_byp", 1'b1, 5'd9, 32'd0);
        tick();
        ask(5'd0, 5'd4);
        rd0("stale", 1'b1, 5'd9, 32'd5);

        launch(5'd6, 5'd1);
        tick();
        commit(5'd6, 5'd1, 32'h10);
        launch(5'd6, 5'd3);
        ask(5'd0, 5'd6);
        rd0("lc_byp", 1'b0, 5'd0, 32'h10);
        tick();
        ask(5'd0, 5'd6);
        rd0("lc", 1'b1, 5'd3, 32'h10);

        launch(5'd1, 5'd11);
        tick();
        launch(5'd2, 5'd12);
        tick();
        launch(5'd8, 5'd4);
        tick();
        ask(5'd2, 5'd1);
        chk("pre_flush", {62'd0, dep_busy}, 64'd3);
        flush_in = 1'b1;
        commit(5'd8, 5'd4, 32'h55);
        launch(5'd9, 5'd13);
        tick();
        ask(5'd2, 5'd1);
        chk("flush_12", {62'd0, dep_busy}, 64'd0);
        ask(5'd9, 5'd8);
        chk("flush_89", {62'd0, dep_busy}, 64'd0);
        rd0("flush8", 1'b0, 5'd0, 32'h55);
        ask(5'd0, 5'd6);
        chk("flush_6", {63'd0, dep_busy[0]}, 64'd0);

        launch(5'd5, 5'd20);
        tick();
        rdy_in = 1'b0;
        commit(5'd5, 5'd20, 32'h77);
        ask(5'd0, 5'd5);
        rd0("stall_nobyp", 1'b1, 5'd20, 32'd0);
        tick();
        chk("stall_id", {59'd0, msg_rob_id}, 64'd4);
        chk("stall_val", {32'd0, msg_value}, 64'h55);
        rdy_in = 1'b1;
        ask(5'd0, 5'd5);
        rd0("stall", 1'b1, 5'd20, 32'd0);

        launch(5'd0, 5'd5);
        commit(5'd0, 5'd5, 32'h1);
        ask(5'd5, 5'd0);
        rd0("x0_byp", 1'b0, 5'd0, 32'd0);
        tick();
        ask(5'd5, 5'd0);
        rd0("x0", 1'b0, 5'd0, 32'd0);
        chk("x0_tag", {59'd0, dep_tag[4:0]}, 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
